// File: rtl/counter_bank.sv
// Bank of CHANNELS saturating-limit counters that wrap to 0 after LIMIT, with load and clear.
// Define COUNTER_BANK_CASCADE_EN to chain channels into one mixed-radix (LIMIT+1) counter.
module counter_bank_lane #(
  parameter int WIDTH = 5,
  parameter int LIMIT = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] ld_val,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cnt_nxt,
  output logic             wrap
);
  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic wrap_nxt;

  always_comb begin
    cnt_nxt  = cnt;
    wrap_nxt = 1'b0;
    if (clear) begin
      cnt_nxt = '0;
    end else if (load) begin
      cnt_nxt = (ld_val > LIM) ? LIM : ld_val;
    end else if (inc) begin
      if (cnt == LIM) begin
        cnt_nxt  = '0;
        wrap_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      wrap <= wrap_nxt;
    end
  end
endmodule

module counter_bank #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int LIMIT    = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] load_data,
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]       wrap,
  output logic                      all_done
);
  localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

  logic [CHANNELS-1:0][WIDTH-1:0] cnt, cnt_nxt, ld_val;
  logic [CHANNELS-1:0]            inc_ev, nxt_lim;

  assign ld_val    = load_data;
  assign count_out = cnt;

`ifdef COUNTER_BANK_CASCADE_EN
  // Carry ripples combinationally: a lane carries only if it actually wraps this edge.
  logic carry;
  always_comb begin
    inc_ev = '0;
    carry  = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      inc_ev[i] = en[i] & carry;
      carry     = inc_ev[i] & (cnt[i] == LIM) & ~load[i] & ~clear;
    end
  end
`else
  assign inc_ev = en;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    counter_bank_lane #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear),
      .load   (load[g]),
      .inc    (inc_ev[g]),
      .ld_val (ld_val[g]),
      .cnt    (cnt[g]),
      .cnt_nxt(cnt_nxt[g]),
      .wrap   (wrap[g])
    );
    assign nxt_lim[g] = (cnt_nxt[g] == LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) all_done <= 1'b0;
    else        all_done <= &nxt_lim;
  end
endmodule

// File: tb/tb_counter_bank.sv
// Self-checking bench for counter_bank: directed table, corner sequences, random vs. model.
module tb_counter_bank;
  localparam int W = 5;
  localparam int C = 4;
  localparam int L = 24;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           clear;
  logic [C-1:0]   en, load;
  logic [C*W-1:0] load_data;
  logic [C*W-1:0] count_out;
  logic [C-1:0]   wrap;
  logic           all_done;

  counter_bank #(.WIDTH(W), .CHANNELS(C), .LIMIT(L)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .en(en), .load(load),
    .load_data(load_data), .count_out(count_out), .wrap(wrap), .all_done(all_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // Reference state: plain integers, wrap-around done with modulo (LIMIT+1).
  int     mcnt[C];
  logic   mwrap[C];
  logic   mdone;

  typedef struct {
    logic           clr;
    logic [C-1:0]   en;
    logic [C-1:0]   ld;
    logic [C*W-1:0] d;
    logic [C*W-1:0] ecnt;
    logic [C-1:0]   ewrap;
    logic           edone;
  } vec_t;

  function automatic logic [C*W-1:0] pk(input int a, input int b, input int c, input int d);
    logic [W-1:0] va, vb, vc, vd;
    va = W'(a); vb = W'(b); vc = W'(c); vd = W'(d);
    return {vd, vc, vb, va};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      mcnt[i] = 0; mwrap[i] = 1'b0;
    end
    mdone = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic [C-1:0] e, input logic [C-1:0] l,
                            input logic [C*W-1:0] d);
    logic ev[C];
    int   nv;
    logic all;
    for (int i = 0; i < C; i++) begin
`ifdef COUNTER_BANK_CASCADE_EN
      // A channel advances only when every lower channel rolls over this cycle.
      if (i == 0) ev[i] = e[0];
      else ev[i] = e[i] && ev[i-1] && (mcnt[i-1] == L) && !l[i-1] && !c;
`else
      ev[i] = e[i];
`endif
    end
    all = 1'b1;
    for (int i = 0; i < C; i++) begin
      mwrap[i] = 1'b0;
      if (c) mcnt[i] = 0;
      else if (l[i]) begin
        nv = int'(d[i*W +: W]);
        mcnt[i] = (nv > L) ? L : nv;
      end else if (ev[i]) begin
        mwrap[i] = (mcnt[i] == L);
        mcnt[i] = (mcnt[i] + 1) % (L + 1);
      end
      if (mcnt[i] != L) all = 1'b0;
    end
    mdone = all;
  endtask

  task automatic drive(input logic c, input logic [C-1:0] e, input logic [C-1:0] l,
                       input logic [C*W-1:0] d);
    @(negedge clk);
    clear = c; en = e; load = l; load_data = d;
    model_step(c, e, l, d);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".cnt"}, 32'(count_out), 32'(pk(mcnt[0], mcnt[1], mcnt[2], mcnt[3])));
    chk({tag, ".wrap"}, 32'(wrap), {28'd0, mwrap[3], mwrap[2], mwrap[1], mwrap[0]});
    chk({tag, ".done"}, 32'(all_done), 32'(mdone));
  endtask

  vec_t tbl[9];

  initial begin
    // Directed sequence starting from a fresh reset release.
    tbl[0] = '{1'b0, 4'b0001, 4'b0000, '0, pk(1, 0, 0, 0), 4'b0000, 1'b0};
    tbl[1] = '{1'b0, 4'b0001, 4'b0000, '0, pk(2, 0, 0, 0), 4'b0000, 1'b0};
    tbl[2] = '{1'b0, 4'b0001, 4'b0000, '0, pk(3, 0, 0, 0), 4'b0000, 1'b0};
    tbl[3] = '{1'b0, 4'b0000, 4'b0001, pk(24, 0, 0, 0), pk(24, 0, 0, 0), 4'b0000, 1'b0};
    tbl[4] = '{1'b0, 4'b0001, 4'b0000, '0, pk(0, 0, 0, 0), 4'b0001, 1'b0};
    tbl[5] = '{1'b0, 4'b0001, 4'b0000, '0, pk(1, 0, 0, 0), 4'b0000, 1'b0};
    tbl[6] = '{1'b0, 4'b0100, 4'b0110, pk(0, 31, 7, 0), pk(1, 24, 7, 0), 4'b0000, 1'b0};
    tbl[7] = '{1'b0, 4'b0000, 4'b1111, pk(24, 24, 24, 24), pk(24, 24, 24, 24), 4'b0000, 1'b1};
    tbl[8] = '{1'b1, 4'b1111, 4'b1111, pk(9, 9, 9, 9), pk(0, 0, 0, 0), 4'b0000, 1'b0};

    rst_n = 1'b0; clear = 1'b0; en = '0; load = '0; load_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.cnt", 32'(count_out), 32'd0);
    chk("reset.wrap", 32'(wrap), 32'd0);
    chk("reset.done", 32'(all_done), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // Get nonzero state with all_done high, then reset between edges.
    drive(1'b0, 4'b0000, 4'b1111, pk(24, 24, 24, 24));
    chk_model("preload");
    drive(1'b0, 4'b0001, 4'b0000, '0);
    chk_model("prewrap");
    @(negedge clk);
    clear = 1'b0; en = '0; load = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("async.cnt", 32'(count_out), 32'd0);
    chk("async.wrap", 32'(wrap), 32'd0);
    chk("async.done", 32'(all_done), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < 9; k++) begin
      drive(tbl[k].clr, tbl[k].en, tbl[k].ld, tbl[k].d);
      chk($sformatf("tbl%0d.cnt", k), 32'(count_out), 32'(tbl[k].ecnt));
      chk($sformatf("tbl%0d.wrap", k), 32'(wrap), 32'(tbl[k].ewrap));
      chk($sformatf("tbl%0d.done", k), 32'(all_done), 32'(tbl[k].edone));
    end

    // Carry corner: ch0, ch1 at LIMIT, ch2 mid-range, all enabled.
    drive(1'b0, 4'b0000, 4'b1111, pk(24, 24, 3, 5));
    drive(1'b0, 4'b1111, 4'b0000, '0);
`ifdef COUNTER_BANK_CASCADE_EN
    chk("carry.cnt", 32'(count_out), 32'(pk(0, 0, 4, 5)));
`else
    chk("carry.cnt", 32'(count_out), 32'(pk(0, 0, 4, 6)));
`endif
    chk("carry.wrap", 32'(wrap), 32'b0011);
    drive(1'b0, 4'b0000, 4'b0000, '0);
    chk("carry.wrapclr", 32'(wrap), 32'b0000);

    // Random traffic, biased toward LIMIT so wraps and carries happen often.
    for (int n = 0; n < 400; n++) begin
      logic           c;
      logic [C-1:0]   e, l;
      logic [C*W-1:0] d;
      c = ($urandom_range(0, 39) == 0);
      e = C'($urandom);
      l = '0;
      for (int i = 0; i < C; i++) begin
        l[i] = ($urandom_range(0, 9) == 0);
        d[i*W +: W] = ($urandom_range(0, 1) == 1) ? W'(L) : W'($urandom);
      end
      drive(c, e, l, d);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
